// File: rtl/ram_dma.sv
// Block copy/fill engine driving one port of the 16 KiB x 8 work RAM.
// Copy alternates RD/WR per byte; fill streams WR cycles; hold freezes the engine.
//
// state | meaning
// IDLE  | waiting for start; transfer parameters latched on acceptance
// RD    | copy only: read source byte (data returns next cycle)
// WR    | write destination byte (fill byte or copied byte)
// FIN   | one-cycle done pulse, back to IDLE
module ram_dma #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic          i_mode,
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_dst,
  input  logic [AW:0]   i_len,
  input  logic [DW-1:0] i_fill,
  input  logic          i_hold,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_ram_ad,
  output logic [DW-1:0] o_ram_din,
  input  logic [DW-1:0] i_ram_dout,
  output logic          o_ram_ce,
  output logic          o_ram_oce,
  output logic          o_ram_wre
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_mode;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_fill;
  logic [DW-1:0] r_dbuf;
  logic          r_dbuf_v;
  logic          r_rd_d;

  logic w_accept;
  logic w_rd_go;
  logic w_wr_go;
  logic w_last;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_rd_go  = (r_state == S_RD) && !i_hold;
  assign w_wr_go  = (r_state == S_WR) && !i_hold;
  assign w_last   = (r_cnt == CNT_ONE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_len == '0) w_state_nxt = S_FIN;
          else if (i_mode) w_state_nxt = S_WR;
          else             w_state_nxt = S_RD;
        end
      end
      S_RD: if (!i_hold) w_state_nxt = S_WR;
      S_WR: begin
        if (!i_hold) begin
          if (w_last)      w_state_nxt = S_FIN;
          else if (r_mode) w_state_nxt = S_WR;
          else             w_state_nxt = S_RD;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_ram_ce  = 1'b0;
    o_ram_wre = 1'b0;
    o_ram_ad  = '0;
    o_ram_din = '0;
    case (r_state)
      S_RD: begin
        o_busy   = 1'b1;
        o_ram_ce = !i_hold;
        o_ram_ad = r_src;
      end
      S_WR: begin
        o_busy    = 1'b1;
        o_ram_ce  = !i_hold;
        o_ram_wre = !i_hold;
        o_ram_ad  = r_dst;
        o_ram_din = r_mode ? r_fill : (r_dbuf_v ? r_dbuf : i_ram_dout);
      end
      S_FIN:   o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_ram_oce = 1'b1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mode <= 1'b0;
      r_src  <= '0;
      r_dst  <= '0;
      r_cnt  <= '0;
      r_fill <= '0;
    end else begin
      if (w_accept) begin
        r_mode <= i_mode;
        r_src  <= i_src;
        r_dst  <= i_dst;
        r_cnt  <= i_len;
        r_fill <= i_fill;
      end
      if (w_rd_go) r_src <= r_src + 1'b1;
      if (w_wr_go) begin
        r_dst <= r_dst + 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // RAM output register refreshes every clock, so a read byte must be parked if WR is held.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_d   <= 1'b0;
      r_dbuf   <= '0;
      r_dbuf_v <= 1'b0;
    end else begin
      r_rd_d <= w_rd_go;
      if (r_rd_d) r_dbuf <= i_ram_dout;
      if (w_wr_go)     r_dbuf_v <= 1'b0;
      else if (r_rd_d) r_dbuf_v <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// Randomized bench for ram_dma: behavioural RAM, reference memory image and
// latency model derived from per-byte transfer rules and the hold pattern.
module tb_ram_dma;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] fill = '0;
  logic [DW-1:0] ram_dout = '0;
  logic          busy, done, ram_ce, ram_oce, ram_wre;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;

  logic [7:0] mem     [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  ram_dma #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_mode(mode),
    .i_src(src), .i_dst(dst), .i_len(len), .i_fill(fill), .i_hold(hold),
    .o_busy(busy), .o_done(done), .o_ram_ad(ram_ad), .o_ram_din(ram_din),
    .i_ram_dout(ram_dout), .o_ram_ce(ram_ce), .o_ram_oce(ram_oce), .o_ram_wre(ram_wre)
  );

  always #5 clk = ~clk;

  // Output register scrambles whenever no read happens, like a free-running RAM output stage.
  always @(posedge clk) begin
    if (ram_ce && ram_wre) mem[ram_ad] <= ram_din;
    if (ram_ce && !ram_wre) ram_dout <= mem[ram_ad];
    else                    ram_dout <= 8'($urandom);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_xfer(input bit m, input int s, input int d, input int n,
                                     input logic [7:0] f);
    for (int i = 0; i < n; i++)
      ref_mem[(d + i) % DEPTH] = m ? f : ref_mem[(s + i) % DEPTH];
  endfunction

  task automatic cmp_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    check_val(tag, diffs, 0);
  endtask

  task automatic run_xfer(input bit m, input int s, input int d, input int n,
                          input logic [7:0] f, input logic [31:0] hmask, input int hpct,
                          input int poke, input string tag);
    bit hp[$];
    int need, prog, c, exp_done;
    bit act;
    need = (n == 0) ? 0 : (m ? n : 2 * n);
    hp.push_back(1'b0);
    prog = 0;
    c = 1;
    while (prog < need) begin
      bit h;
      h = ((c < 32) && hmask[c]) || (int'($urandom_range(99)) < hpct);
      hp.push_back(h);
      if (!h) prog++;
      c++;
    end
    exp_done = c;
    hp.push_back(1'b0);

    @(posedge clk); #1;
    start = 1'b1; mode = m; src = AW'(s); dst = AW'(d); len = (AW+1)'(n); fill = f; hold = 1'b0;
    @(negedge clk);
    check_val({tag, ".idle_busy"}, busy, 0);
    for (int cc = 1; cc <= exp_done; cc++) begin
      @(posedge clk); #1;
      start = (cc == poke);
      mode  = 1'($urandom);
      src   = AW'($urandom);
      dst   = AW'($urandom);
      len   = (AW+1)'($urandom);
      fill  = 8'($urandom);
      hold  = hp[cc];
      @(negedge clk);
      act = (n != 0) && (cc < exp_done);
      check_val({tag, ".busy"}, busy, act);
      check_val({tag, ".done"}, done, cc == exp_done);
      check_val({tag, ".ce"}, ram_ce, act && !hp[cc]);
    end
    start = 1'b0;
    hold  = 1'b0;
    model_xfer(m, s, d, n, f);
    cmp_mem({tag, ".mem"});
  endtask

  initial begin
    int s, d, n;
    logic [7:0] fb;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst.busy", busy, 0);
    check_val("rst.done", done, 0);
    check_val("rst.ce", ram_ce, 0);
    check_val("rst.wre", ram_wre, 0);
    check_val("rst.ad", ram_ad, 0);
    check_val("rst.din", ram_din, 0);
    check_val("rst.oce", ram_oce, 1);
    @(negedge clk);
    reset_n = 1'b1;

    run_xfer(1'b0, 5, 9, 0, 8'h00, 0, 0, 0, "len0");
    fb = 8'($urandom);
    run_xfer(1'b1, 0, 0, DEPTH, fb, 0, 0, 0, "full");
    run_xfer(1'b1, 'h0100, 'h0100, 4, 8'hA5, 0, 0, 0, "fill4");
    check_val("fill4.b104", mem['h0104], fb);

    run_xfer(1'b1, 0, 'h0000, 1, 8'h11, 0, 0, 0, "pre0");
    run_xfer(1'b1, 0, 'h0001, 1, 8'h22, 0, 0, 0, "pre1");
    run_xfer(1'b1, 0, 'h0002, 1, 8'h33, 0, 0, 0, "pre2");
    run_xfer(1'b0, 'h0000, 'h2000, 3, 8'h00, 0, 0, 0, "copy3");
    check_val("copy3.b2002", mem['h2002], 8'h33);

    run_xfer(1'b0, 'h0000, 'h0300, 2, 8'h00, 32'h0000_0064, 0, 0, "hold2");
    check_val("hold2.b0301", mem['h0301], 8'h22);

    run_xfer(1'b1, 0, 'h3FFE, 4, 8'h3C, 0, 0, 0, "wrap");
    check_val("wrap.b0001", mem['h0001], 8'h3C);
    run_xfer(1'b1, 0, 'h0010, 1, 8'h7E, 0, 0, 0, "pre7e");
    run_xfer(1'b0, 'h0010, 'h0011, 3, 8'h00, 0, 0, 0, "ovl");
    check_val("ovl.b0013", mem['h0013], 8'h7E);

    run_xfer(1'b0, 'h0040, 'h0080, 6, 8'h00, 0, 0, 3, "poke");
    run_xfer(1'b1, 'h0000, 'h0500, 5, 8'h5A, 0, 30, 4, "pokef");

    for (int t = 0; t < 30; t++) begin
      s = int'($urandom_range(DEPTH - 1));
      n = int'($urandom_range(40, 1));
      case ($urandom_range(3))
        0:       d = (s + int'($urandom_range(8, 1))) % DEPTH;
        1:       d = s;
        default: d = int'($urandom_range(DEPTH - 1));
      endcase
      run_xfer(1'($urandom), s, d, n, 8'($urandom), 0, 25, 0, "rnd");
    end

    s = 'h0700;
    d = 'h1700;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; src = AW'(s); dst = AW'(d); len = (AW+1)'(10); hold = 1'b0;
    for (int cc = 1; cc <= 3; cc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    check_val("rstmid.pre_wre", ram_wre, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rstmid.busy", busy, 0);
    check_val("rstmid.ce", ram_ce, 0);
    check_val("rstmid.wre", ram_wre, 0);
    check_val("rstmid.ad", ram_ad, 0);
    check_val("rstmid.din", ram_din, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("rstmid.done", done, 0);
    end
    reset_n = 1'b1;
    model_xfer(1'b0, s, d, 1, 8'h00);
    cmp_mem("rstmid.mem");
    run_xfer(1'b0, s, d, 10, 8'h00, 0, 20, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
